// File: rtl/serial_add_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub_pkg
// Description : Shared definitions for the bit-serial adder/subtractor:
//               the FSM state encoding and the operation mode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : serial_add_sub_pkg
`default_nettype wire

// File: rtl/serial_add_sub_fa_s_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_s_cell
// Description : 1-bit combinational full adder / full subtractor.
//               add : s = x + y + cbin,  cbout = carry-out
//               sub : s = x - y - cbin,  cbout = borrow-out
// Ports       : x, y   - operand bits
//               mode   - MODE_ADD / MODE_SUB
//               cbin   - carry-in (add) or borrow-in (subtract)
//               s      - sum / difference bit
//               cbout  - carry-out (add) or borrow-out (subtract)
// Revision    : 1.0 - initial release
// ============================================================================
module fa_s_cell
    import serial_add_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic mode,
    input  logic cbin,
    output logic s,
    output logic cbout
);

    logic w_xa;

    // Sum and difference bits are identical. Inverting x turns the carry
    // equation into the borrow equation: borrow = ~x&y | cbin&~(x^y).
    assign w_xa  = x ^ (mode == MODE_SUB);
    assign s     = x ^ y ^ cbin;
    assign cbout = (w_xa & y) | (cbin & (w_xa ^ y));

endmodule : fa_s_cell
`default_nettype wire

// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub
// Description : Bit-serial two's-complement adder/subtractor. Operands are
//               captured on start, processed LSB first one bit per clock
//               through a single fa_s_cell, and the result is published
//               together with carry/borrow and signed overflow on entry to
//               DONE. One operation takes WIDTH+1 cycles back-to-back.
// Ports       : clk, rst_n (async, active low)
//               start, mode, a, b, cin - request and operands (sampled
//                                        together on start in IDLE/DONE)
//               busy       - operation in progress
//               done       - one-cycle result-valid pulse
//               result     - sum / difference, held until the next done
//               carry_borr - carry-out (add) / borrow-out (subtract)
//               overflow   - signed overflow of the operation
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8     // must be >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_borr,
    output logic             overflow
);

    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;      // operand A, doubles as the result shift-in
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic             r_cb;     // registered carry/borrow between bits
    logic             w_s;
    logic             w_cbout;
    logic             w_capture;
    logic             w_last;
    logic             w_ovf;

    fa_s_cell u_cell (
        .x     (r_a[0]),
        .y     (r_b[0]),
        .mode  (r_mode),
        .cbin  (r_cb),
        .s     (w_s),
        .cbout (w_cbout)
    );

    // A new request is taken in IDLE, or on the edge that leaves DONE so
    // that operations can run back-to-back.
    assign w_capture = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last    = (r_state == RUN) && (r_cnt == C_LAST);

    // On the final bit r_a[0]/r_b[0] are the operand sign bits and w_s is
    // the result sign. Add overflows when signs match, subtract when they
    // differ; either way the result sign must disagree with a.
    assign w_ovf = ~(r_a[0] ^ r_b[0] ^ (r_mode == MODE_SUB)) & (w_s ^ r_a[0]);

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    w_next = w_capture ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_mode     <= 1'b0;
            r_cb       <= 1'b0;
            result     <= '0;
            carry_borr <= 1'b0;
            overflow   <= 1'b0;
        end else if (w_capture) begin
            r_cnt  <= '0;
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
            r_cb   <= cin;
        end else if (r_state == RUN) begin
            // Consumed bits of A leave at the bottom while result bits
            // enter at the top; after WIDTH shifts r_a holds the result.
            r_a   <= {w_s, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_cb  <= w_cbout;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                result     <= {w_s, r_a[WIDTH-1:1]};
                carry_borr <= w_cbout;
                overflow   <= w_ovf;
            end
        end
    end

endmodule : serial_add_sub
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_sub
// Description : Self-checking bench for serial_add_sub (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_borr;
    logic             overflow;

    int tests;
    int fails;

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_borr (carry_borr),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        logic       cin;
        logic [7:0] res;
        logic       cb;
        logic       ov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 9-bit integer arithmetic.
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic mm, input logic mc,
                                  output logic [7:0] r, output logic cb, output logic ov);
        logic [8:0] t;
        if (!mm) t = {1'b0, ma} + {1'b0, mb} + {8'd0, mc};
        else     t = {1'b0, ma} - {1'b0, mb} - {8'd0, mc};
        r  = t[7:0];
        cb = t[8];
        if (!mm) ov = (ma[7] == mb[7]) && (r[7] != ma[7]);
        else     ov = (ma[7] != mb[7]) && (r[7] != ma[7]);
    endfunction

    // Called at a negedge; start is sampled at the following posedge.
    // Inputs are scrambled afterwards to show the captured copy is used.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tm, input logic tc);
        a = ta; b = tb_; mode = tm; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta; b = ~tb_; mode = ~tm; cin = ~tc;
    endtask

    // Counts negedges until done is seen (bounded), recording whether busy
    // stayed high and the published outputs stayed frozen meanwhile.
    task automatic wait_done(output int n, output logic busy_ok, output logic stable_ok);
        logic [7:0] held;
        held      = result;
        n         = 0;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (result !== held) stable_ok = 1'b0;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tm, input logic tc,
                          input logic [7:0] er, input logic ecb, input logic eov);
        int   n;
        logic bok, sok;
        launch(ta, tb_, tm, tc);
        wait_done(n, bok, sok);
        check({name, " latency"}, n, 9);
        check({name, " busy"}, bok, 1'b1);
        check({name, " held"}, sok, 1'b1);
        check({name, " result"}, result, er);
        check({name, " carry_borr"}, carry_borr, ecb);
        check({name, " overflow"}, overflow, eov);
        @(negedge clk);
        check({name, " done width"}, done, 1'b0);
    endtask

    initial begin
        int         n;
        logic       bok, sok;
        logic [7:0] ra, rb, er;
        logic       rm, rc, ecb, eov;

        tests = 0;
        fails = 0;

        //            a      b      mode cin  res    cb    ov
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[8] = '{8'h3C, 8'h42, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
        vecs[9] = '{8'hC0, 8'hA0, 1'b0, 1'b0, 8'h60, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 8'h00);
        check("reset carry_borr", carry_borr, 1'b0);
        check("reset overflow", overflow, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].mode,
                   vecs[i].cin, vecs[i].res, vecs[i].cb, vecs[i].ov);
        end

        // Start pulse in the middle of RUN is ignored.
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        a = 8'hFF; b = 8'hFF; mode = 1'b1; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, bok, sok);
        check("midrun latency", n, 6);
        check("midrun result", result, 8'h46);
        check("midrun carry_borr", carry_borr, 1'b0);
        // Back-to-back: new start sampled on the edge that leaves DONE.
        launch(8'h01, 8'h02, 1'b0, 1'b0);
        wait_done(n, bok, sok);
        check("b2b latency", n, 9);
        check("b2b busy", bok, 1'b1);
        check("b2b result", result, 8'h03);
        @(negedge clk);
        check("b2b done width", done, 1'b0);

        // Reset mid-operation; previous outputs are non-zero.
        run_op("pre-reset", 8'hC0, 8'hA0, 1'b0, 1'b0, 8'h60, 1'b1, 1'b1);
        launch(8'h55, 8'h0F, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort result", result, 8'h00);
        check("abort carry_borr", carry_borr, 1'b0);
        check("abort overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) bok = 1'b0;
        end
        check("abort no done", bok, 1'b1);
        run_op("post-reset", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

        // Random operations against the integer model.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rm, rc, er, ecb, eov);
            run_op($sformatf("rnd%0d a=%0h b=%0h m=%0d c=%0d", i, ra, rb, rm, rc),
                   ra, rb, rm, rc, er, ecb, eov);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_add_sub
`default_nettype wire
